// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Included by the interface, the FIFO and the arbiter top.
package wb_arbiter_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    NORMAL   = 1'b0,
    FORCE_MD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the ALU/mul-div producers and the write-back arbiter.
// The arbiter connects through the slave modport.
interface wb_arbiter_if #(
  parameter int DEPTH = 4
);
  import wb_arbiter_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_add;
  logic [DATA_W-1:0]     alu_data;
  logic                  alu_stall;
  logic                  md_valid;
  logic                  md_ready;
  logic [REG_ADDR_W-1:0] md_add;
  logic [DATA_W-1:0]     md_data;
  logic                  en_write;
  logic [REG_ADDR_W-1:0] write_add;
  logic [DATA_W-1:0]     write_data;
  logic [CNT_W-1:0]      md_count;

  modport master (
    output alu_valid, alu_add, alu_data, md_valid, md_add, md_data,
    input  alu_stall, md_ready, en_write, write_add, write_data, md_count
  );

  modport slave (
    input  alu_valid, alu_add, alu_data, md_valid, md_add, md_data,
    output alu_stall, md_ready, en_write, write_add, write_data, md_count
  );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// Synchronous FIFO holding buffered mul/div results (destination + data).
// Occupancy, full and empty all derive from the registered count.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [REG_ADDR_W-1:0]      push_add,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [REG_ADDR_W-1:0]      head_add,
  output logic [DATA_W-1:0]          head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [REG_ADDR_W-1:0] add_mem_r  [DEPTH];
  logic [DATA_W-1:0]     data_mem_r [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign full      = (count_r == CNT_MAX);
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head_add  = add_mem_r[rd_ptr_r];
  assign head_data = data_mem_r[rd_ptr_r];

  // storage array: contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      add_mem_r[wr_ptr_r]  <= push_add;
      data_mem_r[wr_ptr_r] <= push_data;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results with FIFO-buffered mul/div results onto the
// single register-file write port, with a starvation bound on ALU priority.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_e            state_r, state_nxt_s;
  logic [SW-1:0]         starve_r, starve_nxt_s, starve_inc_s;
  logic                  en_write_r, wr_en_s;
  logic [REG_ADDR_W-1:0] write_add_r, wr_add_s;
  logic [DATA_W-1:0]     write_data_r, wr_data_s;
  logic                  alu_ok_s, push_s, pop_s;
  logic [REG_ADDR_W-1:0] head_add_s;
  logic [DATA_W-1:0]     head_data_s;
  logic [CW-1:0]         count_s;
  logic                  full_s, empty_s;

  // Writes to register 0 are architecturally void: ALU ones are ignored and
  // mul/div ones complete the handshake but are never buffered.
  assign alu_ok_s      = bus.alu_valid && (bus.alu_add != REG_ZERO);
  assign bus.md_ready  = !full_s && !rst;
  assign push_s        = bus.md_valid && bus.md_ready && (bus.md_add != REG_ZERO);
  assign bus.alu_stall = (state_r == FORCE_MD) && !rst;
  assign bus.md_count  = count_s;
  assign bus.en_write  = en_write_r;
  assign bus.write_add = write_add_r;
  assign bus.write_data = write_data_r;
  assign starve_inc_s  = starve_r + STARVE_ONE;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_add  (bus.md_add),
    .push_data (bus.md_data),
    .pop       (pop_s),
    .head_add  (head_add_s),
    .head_data (head_data_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // arbitration decision, starve counter and next state
  always_comb begin
    state_nxt_s  = state_r;
    starve_nxt_s = starve_r;
    pop_s        = 1'b0;
    wr_en_s      = 1'b0;
    wr_add_s     = REG_ZERO;
    wr_data_s    = {DATA_W{1'b0}};
    case (state_r)
      NORMAL: begin
        if (alu_ok_s) begin
          wr_en_s   = 1'b1;
          wr_add_s  = bus.alu_add;
          wr_data_s = bus.alu_data;
          if (!empty_s) begin
            starve_nxt_s = starve_inc_s;
            if (starve_inc_s == STARVE_LIM) begin
              state_nxt_s = FORCE_MD;
            end else begin
              state_nxt_s = NORMAL;
            end
          end else begin
            starve_nxt_s = {SW{1'b0}};
          end
        end else if (!empty_s) begin
          pop_s        = 1'b1;
          wr_en_s      = 1'b1;
          wr_add_s     = head_add_s;
          wr_data_s    = head_data_s;
          starve_nxt_s = {SW{1'b0}};
        end else begin
          starve_nxt_s = {SW{1'b0}};
        end
      end
      FORCE_MD: begin
        if (!empty_s) begin
          pop_s     = 1'b1;
          wr_en_s   = 1'b1;
          wr_add_s  = head_add_s;
          wr_data_s = head_data_s;
        end else begin
          pop_s = 1'b0;
        end
        starve_nxt_s = {SW{1'b0}};
        state_nxt_s  = NORMAL;
      end
      default: begin
        starve_nxt_s = {SW{1'b0}};
        state_nxt_s  = NORMAL;
      end
    endcase
  end

  // state, counter and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= NORMAL;
      starve_r     <= {SW{1'b0}};
      en_write_r   <= 1'b0;
      write_add_r  <= REG_ZERO;
      write_data_r <= {DATA_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      starve_r     <= starve_nxt_s;
      en_write_r   <= wr_en_s;
      write_add_r  <= wr_add_s;
      write_data_r <= wr_data_s;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios then random traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: buffered results in order, consecutive ALU wins, pending forced cycle
  logic [36:0] mq[$];
  int          m_starve;
  bit          m_force;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one clock cycle: check combinational view, advance model, check registered outputs
  task automatic tick();
    bit          rdy, stl, push, wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [36:0] head;
    #1;
    rdy = !rst && (mq.size() < DEPTH);
    stl = !rst && m_force;
    chk("md_ready", 32'(bus.md_ready), 32'(rdy));
    chk("alu_stall", 32'(bus.alu_stall), 32'(stl));
    chk("md_count_pre", 32'(bus.md_count), 32'(mq.size()));
    push = rdy && bus.md_valid && (bus.md_add != 5'd0);
    wr = 1'b0; wa = 5'd0; wd = 32'd0;
    if (rst) begin
      mq.delete();
      m_starve = 0;
      m_force  = 1'b0;
    end else begin
      if (m_force) begin
        if (mq.size() > 0) begin
          head = mq.pop_front();
          wr = 1'b1; wa = head[36:32]; wd = head[31:0];
        end
        m_force  = 1'b0;
        m_starve = 0;
      end else if (bus.alu_valid && bus.alu_add != 5'd0) begin
        wr = 1'b1; wa = bus.alu_add; wd = bus.alu_data;
        if (mq.size() > 0) begin
          m_starve++;
          if (m_starve >= STARVE_MAX) m_force = 1'b1;
        end else begin
          m_starve = 0;
        end
      end else if (mq.size() > 0) begin
        head = mq.pop_front();
        wr = 1'b1; wa = head[36:32]; wd = head[31:0];
        m_starve = 0;
      end else begin
        m_starve = 0;
      end
      if (push) mq.push_back({bus.md_add, bus.md_data});
    end
    @(posedge clk);
    #1;
    chk("en_write", 32'(bus.en_write), 32'(wr));
    chk("write_add", 32'(bus.write_add), 32'(wa));
    chk("write_data", bus.write_data, wd);
    chk("md_count", 32'(bus.md_count), 32'(mq.size()));
  endtask

  task automatic set_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.alu_valid = v; bus.alu_add = a; bus.alu_data = d;
  endtask

  task automatic set_md(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.md_valid = v; bus.md_add = a; bus.md_data = d;
  endtask

  initial begin
    int          n;
    bit          hold;
    logic [4:0]  held_add;
    checks = 0;
    errors = 0;
    m_starve = 0;
    m_force  = 1'b0;
    rst = 1'b1;
    set_alu(1'b0, 5'd0, 32'd0);
    set_md(1'b0, 5'd0, 32'd0);

    // 1 reset for two cycles, then release
    tick();
    tick();
    chk("rst_en_write", 32'(bus.en_write), 32'd0);
    chk("rst_md_ready", 32'(bus.md_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_md_ready", 32'(bus.md_ready), 32'd1);

    // 2 ALU only
    set_alu(1'b1, 5'd10, 32'd101);
    tick();
    chk("alu1_add", 32'(bus.write_add), 32'd10);
    chk("alu1_data", bus.write_data, 32'd101);
    set_alu(1'b1, 5'd11, 32'd200);
    tick();
    chk("alu2_add", 32'(bus.write_add), 32'd11);
    chk("alu2_data", bus.write_data, 32'd200);
    set_alu(1'b0, 5'd0, 32'd0);
    tick();

    // 3 register zero on both sources
    set_alu(1'b1, 5'd0, 32'd55);
    set_md(1'b1, 5'd0, 32'd77);
    #1 chk("zero_md_ready", 32'(bus.md_ready), 32'd1);
    tick();
    chk("zero_en_write", 32'(bus.en_write), 32'd0);
    chk("zero_md_count", 32'(bus.md_count), 32'd0);
    set_alu(1'b0, 5'd0, 32'd0);
    set_md(1'b0, 5'd0, 32'd0);
    tick();
    chk("zero_en_write2", 32'(bus.en_write), 32'd0);

    // 4 ALU priority, then drain
    set_alu(1'b1, 5'd12, 32'h0C0C);
    set_md(1'b1, 5'd5, 32'hAAAA);
    tick();
    chk("prio_add", 32'(bus.write_add), 32'd12);
    set_alu(1'b0, 5'd0, 32'd0);
    set_md(1'b0, 5'd0, 32'd0);
    tick();
    chk("drain_add", 32'(bus.write_add), 32'd5);
    chk("drain_data", bus.write_data, 32'hAAAA);
    chk("drain_count", 32'(bus.md_count), 32'd0);

    // 5 starvation bound
    set_alu(1'b1, 5'd20, 32'd1000);
    set_md(1'b1, 5'd7, 32'h1234);
    tick();
    set_md(1'b0, 5'd0, 32'd0);
    n = 0;
    hold = 1'b0;
    held_add = 5'd0;
    for (int i = 0; i < 10; i++) begin
      if (!hold) begin
        held_add = 5'(21 + i);
        set_alu(1'b1, held_add, 32'(2000 + i));
      end
      hold = m_force;
      tick();
      if (bus.en_write && bus.write_add == 5'd7) break;
      n++;
    end
    chk("starve_alu_writes", 32'(n), 32'd4);
    chk("forced_data", bus.write_data, 32'h1234);
    tick();
    chk("held_alu_add", 32'(bus.write_add), 32'(held_add));
    set_alu(1'b0, 5'd0, 32'd0);
    tick();

    // 6 fill with ALU busy, overflow attempt, reset mid-stream
    for (int i = 0; i < 4; i++) begin
      set_alu(1'b1, 5'(24 + i), 32'(3000 + i));
      set_md(1'b1, 5'(1 + i), 32'(4000 + i));
      tick();
    end
    chk("full_md_ready", 32'(bus.md_ready), 32'd0);
    set_alu(1'b1, 5'd28, 32'd3004);
    set_md(1'b1, 5'd9, 32'd4004);
    tick();
    chk("full_count", 32'(bus.md_count), 32'd4);
    rst = 1'b1;
    tick();
    chk("mid_rst_count", 32'(bus.md_count), 32'd0);
    rst = 1'b0;
    set_alu(1'b0, 5'd0, 32'd0);
    set_md(1'b0, 5'd0, 32'd0);
    tick();
    chk("no_stale_write", 32'(bus.en_write), 32'd0);

    // random traffic against the model
    hold = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!hold) begin
        bus.alu_valid = ($urandom_range(0, 2) != 0);
        bus.alu_add   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.alu_data  = $urandom;
      end
      bus.md_valid = ($urandom_range(0, 1) == 1);
      bus.md_add   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.md_data  = $urandom;
      hold = m_force && !rst;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
